idli_sqi_arb_m: RTL
===================

Name: idli_sqi_arb_m

Overview:
Arbitrates the single external SQI memory between two requesters: instruction fetch (FE) and load/store (LS).
Sequences each 16b read or write transaction nibble-serially on the SQI pins: command, address, dummy (reads only), then data.
Returns read data in parallel to the requester that issued the transaction.
Sits between the fetch/LSU logic and the SQI pads, in the GCK domain.

Parameters:
LS_BURST_MAX, 2, max consecutive LS grants while FE is pending (range 1..3)
CMD_RD, 8'h03, SQI read command byte
CMD_WR, 8'h02, SQI write command byte
DUMMY_NIB, 2, read turnaround nibbles (range 1..4)

Ports:
i_de_gck  in  1  core clock; one nibble per cycle
i_de_rst_n  in  1  reset, asynchronous, active-low
i_fe_req  in  1  fetch read request; held until o_fe_done
i_fe_addr  in  16  fetch address; stable while i_fe_req
o_fe_gnt  out  1  FE accepted this cycle (IDLE only)
o_fe_done  out  1  one-cycle pulse; o_rdata valid for FE
i_ls_req  in  1  load/store request; held until o_ls_done
i_ls_wr  in  1  1 = write, 0 = read
i_ls_addr  in  16  LS address
i_ls_wdata  in  16  LS write data
o_ls_gnt  out  1  LS accepted this cycle
o_ls_done  out  1  one-cycle pulse; o_rdata valid on LS reads
o_rdata  out  16  last read word; holds until next read completes
o_busy  out  1  state != IDLE
o_sqi_cs_n  out  1  chip select, active-low
o_sqi_oe  out  1  SIO output enable
o_sqi_sio  out  4  SIO output nibble
i_sqi_sio  in  4  SIO input nibble

Behaviour:
- Reset values: cs_n=1, oe=0, sio=0, gnt=0, done=0, rdata=0, busy=0, ls_run=0, state IDLE. Reset is asynchronous and applies mid-transaction: cs_n rises immediately, no done pulse is issued, and the partial transaction is discarded.
- States: IDLE -> CMD(2) -> ADDR(4) -> DUMMY(DUMMY_NIB, reads only) -> DATA(4) -> DONE(1) -> IDLE. A 2b nibble counter is used within each state.
- Arbitration happens only in IDLE:
  - Grant LS if i_ls_req && (!i_fe_req || ls_run < LS_BURST_MAX).
  - Otherwise grant FE if i_fe_req.
  - gnt is combinational in that IDLE cycle.
  - On the grant edge, latch requester id, wr, addr and wdata. Later input changes are ignored.
  - ls_run increments (saturating) on an LS grant and clears on an FE grant.
- FE transactions are always reads.
- cs_n is low throughout CMD..DATA and high in IDLE/DONE. The minimum deselect time between transactions is 2 cycles.
- o_sqi_oe is 1 in CMD, ADDR and write DATA. It is 0 in DUMMY, read DATA, IDLE and DONE.
- Nibble order is MS-nibble first for the command, the address and the data.
- Read data: i_sqi_sio is sampled at the rising edge ending each DATA cycle and shifted into o_rdata MSN-first. o_rdata updates on the final sample.
- Latency from grant cycle t0:
  - read (DUMMY_NIB=2): CMD t1–t2, ADDR t3–t6, DUMMY t7–t8, DATA t9–t12, done in t13.
  - write: DATA t7–t10, done in t11.
  - earliest next grant: t14 / t12.
- The done pulse goes to the latched requester only.
- If a requester drops req mid-transaction, the transaction still completes and done still pulses.
- A request that is newly raised while busy waits for IDLE.
- o_sqi_sio is driven to 0 whenever oe=0.

Decomposition:
- Add to idli_pkg: enum sqi_state_t {IDLE, CMD, ADDR, DUMMY, DATA, DONE}, enum sqi_req_t {REQ_FE, REQ_LS}, constants SQI_CMD_RD and SQI_CMD_WR.
- One natural sub-module, idli_sqi_ser_m: a 16b load/shift register that serialises the command/address/wdata nibbles and deserialises read data, controlled by load/shift/dir strobes.
- The FSM and arbitration remain in the top module.

Test Plan:
- FE read 0x1234, memory returns 0xBEEF -> sio out 0,3,1,2,3,4 at t1–t6; oe falls at t7; o_fe_done at t13 with o_rdata=0xBEEF; cs_n high at t13.
- LS write addr 0x00A0, data 0x5A5A -> sio out 0,2,0,0,A,0 then 5,A,5,A; oe=1 at t1–t10; o_ls_done at t11; o_rdata unchanged.
- FE and LS held continuously, LS_BURST_MAX=2 -> grant order LS,LS,FE,LS,LS,FE; no gnt outside IDLE; cs_n high ≥2 cycles between transactions.
- Reset asserted during ADDR -> cs_n=1 and oe=0 asynchronously, no done pulse; after release, reissued FE read completes correctly.
- LS read granted, then i_ls_req dropped and i_ls_addr changed at t4 -> address nibbles unchanged; o_ls_done still pulses at t13.
- DUMMY_NIB=4 FE read -> DATA at t11–t14; done at t15; sampled data matches the memory model.

Source files
------------

// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the SQI memory arbiter.
//   sqi_state_t : transaction sequencer states
//   sqi_req_t   : identity of the requester that owns the current transaction
//   SQI_CMD_RD / SQI_CMD_WR : default SQI command bytes
//   sat_inc2    : 2-bit saturating increment (LS burst run counter)
package idli_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } sqi_state_t;

  typedef enum logic {
    REQ_FE,
    REQ_LS
  } sqi_req_t;

  localparam logic [7:0] SQI_CMD_RD = 8'h03;
  localparam logic [7:0] SQI_CMD_WR = 8'h02;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/idli_sqi_ser_m.sv
// idli_sqi_ser_m: 16-bit load/shift register for the SQI nibble stream.
// The most-significant nibble is always the one on the wire; each shift moves
// the word up by one nibble. Outbound shifts back-fill with zero, inbound
// shifts back-fill with the nibble currently on the SIO input pins.
//   i_de_gck      : core clock
//   load_i        : load load_data_i (takes priority over shift_i)
//   load_data_i   : parallel word to serialise (command / address / wdata)
//   shift_i       : advance one nibble
//   dir_i         : 0 = serialise out, 1 = deserialise in from sio_i
//   sio_i         : SIO input nibble
//   msn_o         : nibble to drive onto SIO this cycle
//   shin_o        : word as it will look after shifting in sio_i this cycle
module idli_sqi_ser_m (
  input  logic        i_de_gck,
  input  logic        load_i,
  input  logic [15:0] load_data_i,
  input  logic        shift_i,
  input  logic        dir_i,
  input  logic [3:0]  sio_i,
  output logic [3:0]  msn_o,
  output logic [15:0] shin_o
);

  logic [15:0] sreg_q;

  // Pure datapath: every transaction reloads the register before it is used.
  always_ff @(posedge i_de_gck) begin
    if (load_i) begin
      sreg_q <= load_data_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[11:0], (dir_i ? sio_i : 4'h0)};
    end
  end

  assign msn_o  = sreg_q[15:12];
  assign shin_o = {sreg_q[11:0], sio_i};

endmodule

// File: rtl/idli_sqi_arb_m.sv
// idli_sqi_arb_m: arbitrates the external SQI memory between instruction
// fetch (FE, reads only) and load/store (LS, reads and writes), and sequences
// each 16-bit transaction nibble-serially: CMD(2) ADDR(4) [DUMMY] DATA(4) DONE.
//   i_de_gck / i_de_rst_n      : core clock, async active-low reset
//   i_fe_req/i_fe_addr         : FE read request, o_fe_gnt / o_fe_done
//   i_ls_req/wr/addr/wdata     : LS request, o_ls_gnt / o_ls_done
//   o_rdata                    : last read word, held until the next read ends
//   o_busy                     : a transaction is in flight
//   o_sqi_cs_n/oe/sio, i_sqi_sio : SQI pad interface
module idli_sqi_arb_m
  import idli_pkg::*;
#(
  parameter int         LS_BURST_MAX = 2,
  parameter logic [7:0] CMD_RD       = SQI_CMD_RD,
  parameter logic [7:0] CMD_WR       = SQI_CMD_WR,
  parameter int         DUMMY_NIB    = 2
) (
  input  logic        i_de_gck,
  input  logic        i_de_rst_n,
  input  logic        i_fe_req,
  input  logic [15:0] i_fe_addr,
  output logic        o_fe_gnt,
  output logic        o_fe_done,
  input  logic        i_ls_req,
  input  logic        i_ls_wr,
  input  logic [15:0] i_ls_addr,
  input  logic [15:0] i_ls_wdata,
  output logic        o_ls_gnt,
  output logic        o_ls_done,
  output logic [15:0] o_rdata,
  output logic        o_busy,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_oe,
  output logic [3:0]  o_sqi_sio,
  input  logic [3:0]  i_sqi_sio
);

  localparam logic [1:0] BURST_MAX  = 2'(LS_BURST_MAX);
  localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_NIB - 1);

  sqi_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  ls_run_q, ls_run_d;
  sqi_req_t    req_q;
  logic        wr_q;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] rdata_q;
  logic        cs_n_q, oe_q, done_q, busy_q;

  logic        fe_gnt, ls_gnt;
  logic        ser_load, ser_shift, ser_dir;
  logic [15:0] ser_ld_data;
  logic [3:0]  ser_msn;
  logic [15:0] ser_shin;
  logic        rd_last;

  idli_sqi_ser_m u_ser (
    .i_de_gck    (i_de_gck),
    .load_i      (ser_load),
    .load_data_i (ser_ld_data),
    .shift_i     (ser_shift),
    .dir_i       (ser_dir),
    .sio_i       (i_sqi_sio),
    .msn_o       (ser_msn),
    .shin_o      (ser_shin)
  );

  // Next-state, arbitration and serialiser strobes. The serialiser is loaded
  // on the edge that enters CMD (command byte), ADDR (address) and, for
  // writes, DATA (write data); otherwise it shifts one nibble per cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ls_run_d    = ls_run_q;
    fe_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    ser_load    = 1'b0;
    ser_ld_data = '0;
    ser_shift   = 1'b0;
    ser_dir     = 1'b0;
    rd_last     = 1'b0;
    case (state_q)
      IDLE: begin
        // LS wins unless FE is waiting and LS has used up its burst allowance.
        if (i_ls_req && (!i_fe_req || (ls_run_q < BURST_MAX))) begin
          ls_gnt   = 1'b1;
          ls_run_d = sat_inc2(ls_run_q);
        end else if (i_fe_req) begin
          fe_gnt   = 1'b1;
          ls_run_d = '0;
        end
        if (ls_gnt || fe_gnt) begin
          state_d     = CMD;
          cnt_d       = '0;
          ser_load    = 1'b1;
          ser_ld_data = {((ls_gnt && i_ls_wr) ? CMD_WR : CMD_RD), 8'h00};
        end
      end
      CMD: begin
        if (cnt_q == 2'd1) begin
          state_d     = ADDR;
          cnt_d       = '0;
          ser_load    = 1'b1;
          ser_ld_data = addr_q;
        end else begin
          cnt_d     = cnt_q + 2'd1;
          ser_shift = 1'b1;
        end
      end
      ADDR: begin
        if (cnt_q == 2'd3) begin
          cnt_d = '0;
          if (wr_q) begin
            state_d     = DATA;
            ser_load    = 1'b1;
            ser_ld_data = wdata_q;
          end else begin
            state_d = DUMMY;
          end
        end else begin
          cnt_d     = cnt_q + 2'd1;
          ser_shift = 1'b1;
        end
      end
      DUMMY: begin
        if (cnt_q == DUMMY_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DATA: begin
        ser_shift = 1'b1;
        ser_dir   = !wr_q;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          cnt_d   = '0;
          rd_last = !wr_q;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, arbitration bookkeeping and registered pad/handshake outputs.
  always_ff @(posedge i_de_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ls_run_q <= '0;
      req_q    <= REQ_FE;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      cs_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ls_run_q <= ls_run_d;
      if (ls_gnt || fe_gnt) begin
        req_q <= ls_gnt ? REQ_LS : REQ_FE;
        wr_q  <= ls_gnt && i_ls_wr;
      end
      if (rd_last) begin
        rdata_q <= ser_shin;
      end
      cs_n_q <= !((state_d == CMD) || (state_d == ADDR) ||
                  (state_d == DUMMY) || (state_d == DATA));
      oe_q   <= (state_d == CMD) || (state_d == ADDR) ||
                ((state_d == DATA) && wr_q);
      done_q <= (state_d == DONE);
      busy_q <= (state_d != IDLE);
    end
  end

  // Transaction operands are captured once at grant; later input changes
  // have no effect on the transaction in flight.
  always_ff @(posedge i_de_gck) begin
    if (ls_gnt) begin
      addr_q  <= i_ls_addr;
      wdata_q <= i_ls_wdata;
    end else if (fe_gnt) begin
      addr_q  <= i_fe_addr;
      wdata_q <= '0;
    end
  end

  // Grants are combinational in the IDLE cycle; suppressed while in reset.
  assign o_fe_gnt   = fe_gnt && i_de_rst_n;
  assign o_ls_gnt   = ls_gnt && i_de_rst_n;
  assign o_fe_done  = done_q && (req_q == REQ_FE);
  assign o_ls_done  = done_q && (req_q == REQ_LS);
  assign o_rdata    = rdata_q;
  assign o_busy     = busy_q;
  assign o_sqi_cs_n = cs_n_q;
  assign o_sqi_oe   = oe_q;
  assign o_sqi_sio  = oe_q ? ser_msn : 4'h0;

endmodule
